// File: rtl/common_defs_pkg.sv
// Shared AXI bundle types and arbiter state encoding used by the memory-side arbiters.
package common_defs;

    // AXI master-to-slave request bundle (IDs carried on separate ports)
    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
        logic        awvalid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_req_t;

    // AXI slave-to-master response bundle
    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
    } axi_resp_t;

    // Transaction-locked arbiter phases
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_BUSY = 3'd1,
        WR_ADDR = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time gets the grant.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Pick the lone requester, or alternate away from last_grant on a tie
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req[1];
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one external AXI master port between the icache (port 0) and dcache (port 1).
// The bus is locked to a single requester from AR/AW acceptance through R-last or B.
import common_defs::*;

module axi_mem_arbiter #(
    parameter int BUS_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  axi_req_t             s0_req,
    input  logic [BUS_WIDTH-1:0] s0_req_arid,
    output axi_resp_t            s0_resp,
    output logic [BUS_WIDTH-1:0] s0_resp_rid,
    input  axi_req_t             s1_req,
    input  logic [BUS_WIDTH-1:0] s1_req_arid,
    input  logic [BUS_WIDTH-1:0] s1_req_awid,
    input  logic [BUS_WIDTH-1:0] s1_req_wid,
    output axi_resp_t            s1_resp,
    output logic [BUS_WIDTH-1:0] s1_resp_rid,
    output logic [BUS_WIDTH-1:0] s1_resp_bid,
    output axi_req_t             m_req,
    output logic [BUS_WIDTH-1:0] m_req_arid,
    output logic [BUS_WIDTH-1:0] m_req_awid,
    output logic [BUS_WIDTH-1:0] m_req_wid,
    input  axi_resp_t            m_resp,
    input  logic [BUS_WIDTH-1:0] m_resp_rid,
    input  logic [BUS_WIDTH-1:0] m_resp_bid
);

    arb_state_t state;
    arb_state_t state_next;
    logic       owner;
    logic       last_grant;
    logic       ar_done;
    logic       grant_valid;
    logic       grant_idx;
    logic       pick_read;
    axi_req_t   own_req;
    axi_resp_t  fwd;

    // Port 0 only ever issues reads, so its awvalid does not count as a request
    arb_rr2 u_rr (
        .req        ({s1_req.arvalid | s1_req.awvalid, s0_req.arvalid}),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    assign own_req   = owner ? s1_req : s0_req;
    // A requester presenting both AR and AW is served read-first
    assign pick_read = grant_idx ? s1_req.arvalid : 1'b1;

    // State, owner, round-robin history and single-AR-per-grant tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            ar_done    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_valid) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state != RD_BUSY) begin
                ar_done <= 1'b0;
            end else if (m_req.arvalid && m_resp.arready) begin
                ar_done <= 1'b1;
            end
        end
    end

    // Next state plus owner-gated forwarding of handshakes in both directions
    always_comb begin
        state_next = state;

        m_req         = own_req;
        m_req.arvalid = 1'b0;
        m_req.rready  = 1'b0;
        m_req.awvalid = 1'b0;
        m_req.wvalid  = 1'b0;
        m_req.bready  = 1'b0;
        m_req_arid    = owner ? s1_req_arid : s0_req_arid;
        m_req_awid    = owner ? s1_req_awid : '0;
        m_req_wid     = owner ? s1_req_wid  : '0;

        fwd         = m_resp;
        fwd.arready = 1'b0;
        fwd.rvalid  = 1'b0;
        fwd.awready = 1'b0;
        fwd.wready  = 1'b0;
        fwd.bvalid  = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = pick_read ? RD_BUSY : WR_ADDR;
                end
            end
            RD_BUSY: begin
                m_req.arvalid = own_req.arvalid & ~ar_done;
                m_req.rready  = own_req.rready;
                fwd.arready   = m_resp.arready & ~ar_done;
                fwd.rvalid    = m_resp.rvalid;
                if (m_resp.rvalid && own_req.rready && m_resp.rlast) begin
                    state_next = IDLE;
                end
            end
            WR_ADDR: begin
                m_req.awvalid = own_req.awvalid;
                fwd.awready   = m_resp.awready;
                if (own_req.awvalid && m_resp.awready) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                m_req.wvalid = own_req.wvalid;
                fwd.wready   = m_resp.wready;
                if (own_req.wvalid && m_resp.wready && own_req.wlast) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                m_req.bready = own_req.bready;
                fwd.bvalid   = m_resp.bvalid;
                if (m_resp.bvalid && own_req.bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        s0_resp         = m_resp;
        s0_resp.arready = 1'b0;
        s0_resp.rvalid  = 1'b0;
        s0_resp.awready = 1'b0;
        s0_resp.wready  = 1'b0;
        s0_resp.bvalid  = 1'b0;
        s1_resp         = s0_resp;
        if (owner) begin
            s1_resp = fwd;
        end else begin
            s0_resp = fwd;
        end
        s0_resp_rid = m_resp_rid;
        s1_resp_rid = m_resp_rid;
        s1_resp_bid = m_resp_bid;
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed self-checking bench for the two-port AXI memory arbiter.
import common_defs::*;

module tb_axi_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    axi_req_t   s0_req, s1_req, m_req;
    axi_resp_t  s0_resp, s1_resp, m_resp;
    logic [3:0] s0_req_arid, s1_req_arid, s1_req_awid, s1_req_wid;
    logic [3:0] s0_resp_rid, s1_resp_rid, s1_resp_bid;
    logic [3:0] m_req_arid, m_req_awid, m_req_wid, m_resp_rid, m_resp_bid;
    int checks = 0;
    int errors = 0;

    axi_mem_arbiter #(.BUS_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_req_arid(s0_req_arid), .s0_resp(s0_resp), .s0_resp_rid(s0_resp_rid),
        .s1_req(s1_req), .s1_req_arid(s1_req_arid), .s1_req_awid(s1_req_awid), .s1_req_wid(s1_req_wid),
        .s1_resp(s1_resp), .s1_resp_rid(s1_resp_rid), .s1_resp_bid(s1_resp_bid),
        .m_req(m_req), .m_req_arid(m_req_arid), .m_req_awid(m_req_awid), .m_req_wid(m_req_wid),
        .m_resp(m_resp), .m_resp_rid(m_resp_rid), .m_resp_bid(m_resp_bid)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1;
        s0_req = '0; s1_req = '0; m_resp = '0;
        s0_req_arid = 4'h0; s1_req_arid = 4'h0; s1_req_awid = 4'h0; s1_req_wid = 4'h0;
        m_resp_rid = 4'h0; m_resp_bid = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Slave side of a read whose AR is currently visible; returns at the negedge after rlast
    task automatic slave_read(input int port, input int n, input logic [3:0] id);
        m_resp.arready = 1'b1;
        @(negedge clk);
        m_resp.arready = 1'b0;
        if (port == 0) s0_req.arvalid = 1'b0; else s1_req.arvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            m_resp.rvalid = 1'b1;
            m_resp.rdata  = 32'hB000_0000 + 32'(i);
            m_resp.rlast  = (i == n - 1);
            m_resp_rid    = id;
            @(negedge clk);
        end
        m_resp.rvalid = 1'b0;
        m_resp.rlast  = 1'b0;
    endtask

    // Slave side of a single-beat s1 write whose AW is currently visible
    task automatic slave_write(input logic [3:0] id);
        m_resp.awready = 1'b1;
        @(negedge clk);
        m_resp.awready = 1'b0; s1_req.awvalid = 1'b0; m_resp.wready = 1'b1;
        @(negedge clk);
        m_resp.wready = 1'b0; s1_req.wvalid = 1'b0; m_resp.bvalid = 1'b1; m_resp_bid = id;
        @(negedge clk);
        m_resp.bvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s0_req = '0; s1_req = '0; m_resp = '0;
        s0_req_arid = 4'h0; s1_req_arid = 4'h0; s1_req_awid = 4'h0; s1_req_wid = 4'h0;
        m_resp_rid = 4'h0; m_resp_bid = 4'h0;
        s0_req.arvalid = 1'b1; s0_req.rready = 1'b1;
        m_resp.arready = 1'b1; m_resp.rvalid = 1'b1; m_resp.bvalid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({m_req.arvalid, m_req.awvalid, m_req.wvalid, m_req.rready, m_req.bready} !== 5'b0) begin
            errors++; $display("FAIL reset_m_valids got %b want 00000", {m_req.arvalid, m_req.awvalid, m_req.wvalid, m_req.rready, m_req.bready}); end
        checks++; if ({s0_resp.arready, s0_resp.awready, s0_resp.wready, s0_resp.rvalid, s0_resp.bvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_s0_resp got %b want 00000", {s0_resp.arready, s0_resp.awready, s0_resp.wready, s0_resp.rvalid, s0_resp.bvalid}); end
        checks++; if ({s1_resp.arready, s1_resp.awready, s1_resp.wready, s1_resp.rvalid, s1_resp.bvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_s1_resp got %b want 00000", {s1_resp.arready, s1_resp.awready, s1_resp.wready, s1_resp.rvalid, s1_resp.bvalid}); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, IDLE); end
        checks++; if (dut.last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant got %b want 1", dut.last_grant); end
        s0_req = '0; m_resp = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        s0_req.arvalid = 1'b1; s0_req.araddr = 32'h1FC0_0000; s0_req.arlen = 8'd7; s0_req.rready = 1'b1;
        s0_req_arid = 4'h3;
        #1;
        checks++; if (m_req.arvalid !== 1'b0) begin errors++; $display("FAIL rd_idle_no_fwd got %b want 0", m_req.arvalid); end
        @(negedge clk); #1;
        checks++; if (m_req.arvalid !== 1'b1) begin errors++; $display("FAIL rd_arvalid_plus1 got %b want 1", m_req.arvalid); end
        checks++; if (m_req.araddr !== 32'h1FC0_0000) begin errors++; $display("FAIL rd_araddr got %h want 1fc00000", m_req.araddr); end
        checks++; if (m_req.arlen !== 8'd7) begin errors++; $display("FAIL rd_arlen got %0d want 7", m_req.arlen); end
        checks++; if (m_req_arid !== 4'h3) begin errors++; $display("FAIL rd_arid got %h want 3", m_req_arid); end
        m_resp.arready = 1'b1; #1;
        checks++; if (s0_resp.arready !== 1'b1) begin errors++; $display("FAIL rd_s0_arready got %b want 1", s0_resp.arready); end
        checks++; if (s1_resp.arready !== 1'b0) begin errors++; $display("FAIL rd_s1_arready got %b want 0", s1_resp.arready); end
        @(negedge clk);
        m_resp.arready = 1'b0; s0_req.arvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_resp.rvalid = 1'b1; m_resp.rdata = 32'hA000_0000 + 32'(i); m_resp.rlast = (i == 7); m_resp_rid = 4'h3;
            #1;
            checks++; if (s0_resp.rvalid !== 1'b1 || s0_resp.rdata !== 32'hA000_0000 + 32'(i)) begin
                errors++; $display("FAIL rd_beat%0d_s0 got v=%b d=%h want v=1 d=%h", i, s0_resp.rvalid, s0_resp.rdata, 32'hA000_0000 + 32'(i)); end
            checks++; if (s1_resp.rvalid !== 1'b0) begin errors++; $display("FAIL rd_beat%0d_s1_rvalid got %b want 0", i, s1_resp.rvalid); end
            if (i == 0) begin
                checks++; if (s0_resp_rid !== 4'h3) begin errors++; $display("FAIL rd_rid got %h want 3", s0_resp_rid); end
            end
            @(negedge clk);
        end
        m_resp.rvalid = 1'b0; m_resp.rlast = 1'b0; #1;
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rd_end_idle got %0d want %0d", dut.state, IDLE); end
    endtask

    task automatic test_tie();
        apply_reset();
        s0_req.arvalid = 1'b1; s0_req.araddr = 32'h0000_0100; s0_req.arlen = 8'd0; s0_req.rready = 1'b1;
        s1_req.arvalid = 1'b1; s1_req.araddr = 32'h0000_0200; s1_req.arlen = 8'd0; s1_req.rready = 1'b1;
        @(negedge clk); #1;
        checks++; if (m_req.araddr !== 32'h0000_0100 || m_req.arvalid !== 1'b1) begin
            errors++; $display("FAIL tie1_s0_first got a=%h v=%b want a=00000100 v=1", m_req.araddr, m_req.arvalid); end
        slave_read(0, 1, 4'h1);
        s0_req.arvalid = 1'b1; s0_req.araddr = 32'h0000_0104;
        #1;
        checks++; if (m_req.arvalid !== 1'b0) begin errors++; $display("FAIL tie_bubble got %b want 0", m_req.arvalid); end
        @(negedge clk); #1;
        checks++; if (m_req.araddr !== 32'h0000_0200 || dut.owner !== 1'b1) begin
            errors++; $display("FAIL tie2_s1_first got a=%h o=%b want a=00000200 o=1", m_req.araddr, dut.owner); end
        slave_read(1, 1, 4'h2);
        @(negedge clk); #1;
        checks++; if (m_req.araddr !== 32'h0000_0104 || m_req.arvalid !== 1'b1) begin
            errors++; $display("FAIL tie2_s0_next got a=%h v=%b want a=00000104 v=1", m_req.araddr, m_req.arvalid); end
        slave_read(0, 1, 4'h1);
    endtask

    task automatic test_write_during_read();
        s0_req.arvalid = 1'b1; s0_req.araddr = 32'h1FC0_0040; s0_req.arlen = 8'd7;
        @(negedge clk);
        s1_req.awvalid = 1'b1; s1_req.awaddr = 32'h8000_0010; s1_req.awlen = 8'd0;
        s1_req.wvalid = 1'b1; s1_req.wdata = 32'hDEAD_BEEF; s1_req.wstrb = 4'hF; s1_req.wlast = 1'b1; s1_req.bready = 1'b1;
        s1_req_awid = 4'h5; s1_req_wid = 4'h5;
        m_resp.awready = 1'b1; m_resp.wready = 1'b1;
        m_resp.arready = 1'b1;
        @(negedge clk);
        m_resp.arready = 1'b0; s0_req.arvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_resp.rvalid = 1'b1; m_resp.rdata = 32'(i); m_resp.rlast = (i == 7);
            #1;
            checks++; if (s1_resp.awready !== 1'b0 || m_req.awvalid !== 1'b0 || m_req.wvalid !== 1'b0) begin
                errors++; $display("FAIL wdr_beat%0d_gated got awr=%b awv=%b wv=%b want 0 0 0", i, s1_resp.awready, m_req.awvalid, m_req.wvalid); end
            @(negedge clk);
        end
        m_resp.rvalid = 1'b0; m_resp.rlast = 1'b0; m_resp.awready = 1'b0; m_resp.wready = 1'b0;
        #1;
        checks++; if (m_req.awvalid !== 1'b0 || dut.state !== IDLE) begin
            errors++; $display("FAIL wdr_bubble got awv=%b st=%0d want 0 %0d", m_req.awvalid, dut.state, IDLE); end
        @(negedge clk); #1;
        checks++; if (m_req.awvalid !== 1'b1 || m_req.awaddr !== 32'h8000_0010 || m_req_awid !== 4'h5) begin
            errors++; $display("FAIL wdr_aw got v=%b a=%h id=%h want 1 80000010 5", m_req.awvalid, m_req.awaddr, m_req_awid); end
        checks++; if (m_req.wvalid !== 1'b0) begin errors++; $display("FAIL wdr_w_early got %b want 0", m_req.wvalid); end
        m_resp.awready = 1'b1; #1;
        checks++; if (s1_resp.awready !== 1'b1) begin errors++; $display("FAIL wdr_s1_awready got %b want 1", s1_resp.awready); end
        @(negedge clk);
        m_resp.awready = 1'b0; s1_req.awvalid = 1'b0; #1;
        checks++; if (m_req.wvalid !== 1'b1 || m_req.wdata !== 32'hDEAD_BEEF || m_req_wid !== 4'h5 || m_req.wlast !== 1'b1) begin
            errors++; $display("FAIL wdr_w got v=%b d=%h id=%h l=%b want 1 deadbeef 5 1", m_req.wvalid, m_req.wdata, m_req_wid, m_req.wlast); end
        m_resp.wready = 1'b1; #1;
        checks++; if (s1_resp.wready !== 1'b1) begin errors++; $display("FAIL wdr_s1_wready got %b want 1", s1_resp.wready); end
        @(negedge clk);
        m_resp.wready = 1'b0; s1_req.wvalid = 1'b0; m_resp.bvalid = 1'b1; m_resp_bid = 4'h5; #1;
        checks++; if (m_req.bready !== 1'b1 || s1_resp.bvalid !== 1'b1 || s1_resp_bid !== 4'h5 || s0_resp.bvalid !== 1'b0) begin
            errors++; $display("FAIL wdr_b got br=%b bv1=%b id=%h bv0=%b want 1 1 5 0", m_req.bready, s1_resp.bvalid, s1_resp_bid, s0_resp.bvalid); end
        @(negedge clk);
        m_resp.bvalid = 1'b0; #1;
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL wdr_end_idle got %0d want %0d", dut.state, IDLE); end
    endtask

    task automatic test_read_before_write();
        s1_req.arvalid = 1'b1; s1_req.araddr = 32'h0000_0300; s1_req.arlen = 8'd0; s1_req.rready = 1'b1;
        s1_req.awvalid = 1'b1; s1_req.awaddr = 32'h0000_0400; s1_req.wvalid = 1'b1; s1_req.wdata = 32'h1;
        s1_req.wlast = 1'b1; s1_req.bready = 1'b1; s1_req_awid = 4'h6; s1_req_wid = 4'h6;
        @(negedge clk); #1;
        checks++; if (dut.state !== RD_BUSY || m_req.arvalid !== 1'b1 || m_req.awvalid !== 1'b0) begin
            errors++; $display("FAIL rbw_read_first got st=%0d arv=%b awv=%b want %0d 1 0", dut.state, m_req.arvalid, m_req.awvalid, RD_BUSY); end
        slave_read(1, 1, 4'h6);
        @(negedge clk); #1;
        checks++; if (dut.state !== WR_ADDR || m_req.awaddr !== 32'h0000_0400 || m_req.awvalid !== 1'b1) begin
            errors++; $display("FAIL rbw_then_aw got st=%0d a=%h v=%b want %0d 00000400 1", dut.state, m_req.awaddr, m_req.awvalid, WR_ADDR); end
        slave_write(4'h6);
    endtask

    task automatic test_slow_bresp();
        s1_req.awvalid = 1'b1; s1_req.awaddr = 32'h0000_0800; s1_req.wvalid = 1'b1; s1_req.wdata = 32'h2;
        s1_req.wlast = 1'b1; s1_req.bready = 1'b1; s1_req_awid = 4'h7; s1_req_wid = 4'h7;
        @(negedge clk);
        m_resp.awready = 1'b1;
        @(negedge clk);
        m_resp.awready = 1'b0; s1_req.awvalid = 1'b0; m_resp.wready = 1'b1;
        @(negedge clk);
        m_resp.wready = 1'b0; s1_req.wvalid = 1'b0;
        s0_req.arvalid = 1'b1; s0_req.araddr = 32'h0000_0500; s0_req.arlen = 8'd0; m_resp.arready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (dut.state !== WR_RESP || m_req.arvalid !== 1'b0 || s0_resp.arready !== 1'b0) begin
                errors++; $display("FAIL slowb_wait%0d got st=%0d arv=%b arr=%b want %0d 0 0", i, dut.state, m_req.arvalid, s0_resp.arready, WR_RESP); end
            @(negedge clk);
        end
        m_resp.arready = 1'b0; m_resp.bvalid = 1'b1; m_resp_bid = 4'h7; #1;
        checks++; if (s1_resp.bvalid !== 1'b1 || s1_resp_bid !== 4'h7) begin
            errors++; $display("FAIL slowb_b got v=%b id=%h want 1 7", s1_resp.bvalid, s1_resp_bid); end
        @(negedge clk);
        m_resp.bvalid = 1'b0;
        @(negedge clk); #1;
        checks++; if (m_req.arvalid !== 1'b1 || m_req.araddr !== 32'h0000_0500) begin
            errors++; $display("FAIL slowb_s0_after got v=%b a=%h want 1 00000500", m_req.arvalid, m_req.araddr); end
        slave_read(0, 1, 4'h0);
    endtask

    task automatic test_reset_mid_read();
        s0_req.arvalid = 1'b1; s0_req.araddr = 32'h0000_0600; s0_req.arlen = 8'd7; s0_req.rready = 1'b1;
        @(negedge clk);
        m_resp.arready = 1'b1;
        @(negedge clk);
        m_resp.arready = 1'b0; s0_req.arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_resp.rvalid = 1'b1; m_resp.rdata = 32'(i); m_resp.rlast = 1'b0;
            @(negedge clk);
        end
        s0_req.arvalid = 1'b1;
        m_resp.rvalid = 1'b1; m_resp.rdata = 32'd3; #1;
        checks++; if (m_req.rready !== 1'b1) begin errors++; $display("FAIL rstmid_pre_rready got %b want 1", m_req.rready); end
        rst = 1'b1; #1;
        checks++; if (m_req.rready !== 1'b0 || m_req.arvalid !== 1'b0 || s0_resp.rvalid !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop got rr=%b arv=%b rv=%b want 0 0 0", m_req.rready, m_req.arvalid, s0_resp.rvalid); end
        @(negedge clk);
        rst = 1'b0; m_resp = '0; s0_req = '0; #1;
        checks++; if (dut.last_grant !== 1'b1) begin errors++; $display("FAIL rstmid_last_grant got %b want 1", dut.last_grant); end
        s1_req.arvalid = 1'b1; s1_req.araddr = 32'h0000_0700; s1_req.arlen = 8'd0; s1_req.rready = 1'b1;
        @(negedge clk); #1;
        checks++; if (m_req.arvalid !== 1'b1 || m_req.araddr !== 32'h0000_0700 || dut.owner !== 1'b1) begin
            errors++; $display("FAIL rstmid_s1_grant got v=%b a=%h o=%b want 1 00000700 1", m_req.arvalid, m_req.araddr, dut.owner); end
        slave_read(1, 1, 4'h0);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_write_during_read();
        test_read_before_write();
        test_slow_bresp();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
